// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux8
// Purpose  : TDM serial-to-parallel receiver. It rebuilds an 8-bit word from
//            one bit per slot (slot 0 is marked by sync). The optional even
//            parity slot is enabled by the macro TDM_DEMUX8_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_i,
  input  logic       din_valid_i,
  input  logic       sync_i,
  output logic [7:0] dout_o,
  output logic       dout_valid_o,
  output logic [2:0] sel_o,
  output logic       err_o
);

`ifdef TDM_DEMUX8_PARITY_EN
  localparam int NSLOT = 9;
`else
  localparam int NSLOT = 8;
`endif
  localparam int          IDXW = $clog2(NSLOT);
  localparam logic [3:0]  LAST = 4'(NSLOT - 1);
  localparam logic [7:0]  IDLE_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [NSLOT-1:0]   buf_q, buf_d;
  logic [7:0]         idle_q, idle_d;
  logic [7:0]         dout_q, dout_d;
  logic               dv_q, dv_d;
  logic               err_q, err_d;
  logic [NSLOT-1:0]   w_asm;
  logic               w_perr;

  // Frame contents with the bit currently on the wire merged into its slot.
  always_comb begin
    w_asm = buf_q;
    w_asm[sel_q[IDXW-1:0]] = din_i;
  end

`ifdef TDM_DEMUX8_PARITY_EN
  assign w_perr = ^w_asm;
`else
  assign w_perr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    buf_d   = buf_q;
    idle_d  = idle_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      HUNT: begin
        idle_d = '0;
        if (din_valid_i && sync_i) begin
          buf_d    = '0;
          buf_d[0] = din_i;
          sel_d    = 4'd1;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (din_valid_i) begin
          idle_d = '0;
          if (sync_i) begin
            // Early resync: drop the partial frame and restart at slot 1.
            err_d    = 1'b1;
            buf_d    = '0;
            buf_d[0] = din_i;
            sel_d    = 4'd1;
          end else if (sel_q == LAST) begin
            dout_d  = w_asm[7:0];
            dv_d    = 1'b1;
            err_d   = w_perr;
            sel_d   = '0;
            state_d = HUNT;
          end else begin
            buf_d = w_asm;
            sel_d = sel_q + 4'd1;
          end
        end else if (idle_q == IDLE_LIMIT) begin
          err_d   = 1'b1;
          sel_d   = '0;
          idle_d  = '0;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q   <= '0;
      buf_q   <= '0;
      idle_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
      idle_q  <= idle_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dv_q;
  assign sel_o        = sel_q[2:0];
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux8
// Purpose  : Directed bench for tdm_demux8 with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;
  localparam int TIMEOUT = 16;
`ifdef TDM_DEMUX8_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, sync = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, err;
  logic [2:0] sel;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux8 #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .din_i(din), .din_valid_i(din_valid), .sync_i(sync),
    .dout_o(dout), .dout_valid_o(dout_valid), .sel_o(sel), .err_o(err)
  );

  always #5 clk = ~clk;

  // Frame-level model: collect bits into an array, emit a word when full.
  logic [7:0] m_dout = 8'h00;
  logic       m_dv = 1'b0, m_err = 1'b0;
  bit         in_frame = 0;
  int         nbits = 0, idle = 0;
  bit         bits [0:8];

  always @(posedge clk) begin
    m_dv  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_dout = 8'h00; in_frame = 0; nbits = 0; idle = 0;
    end else if (din_valid && sync) begin
      if (in_frame) m_err = 1'b1;
      in_frame = 1; bits[0] = din; nbits = 1; idle = 0;
    end else if (din_valid && in_frame) begin
      bits[nbits] = din; nbits++; idle = 0;
      if (nbits == FRAME) begin
        int par;
        par = 0;
        for (int k = 0; k < 8; k++) m_dout[k] = bits[k];
        for (int k = 0; k < FRAME; k++) par ^= int'(bits[k]);
        m_dv = 1'b1;
        if (FRAME == 9 && par != 0) m_err = 1'b1;
        in_frame = 0; nbits = 0;
      end
    end else if (in_frame) begin
      idle++;
      if (idle == TIMEOUT) begin
        m_err = 1'b1; in_frame = 0; nbits = 0; idle = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model.dout", dout, m_dout);
    check("model.dout_valid", dout_valid, m_dv);
    check("model.err", err, m_err);
    check("model.sel", sel, in_frame ? (nbits % 8) : 0);
  end

  task automatic send(input logic b, input logic s);
    din = b; din_valid = 1'b1; sync = s;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0; din = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_slots(input logic [7:0] w, input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) send(w[k], k == 0);
  endtask

  // Slots 8 (parity, when built in) with an optional deliberate flip.
  task automatic send_tail(input logic [7:0] w, input logic flip);
`ifdef TDM_DEMUX8_PARITY_EN
    send((^w) ^ flip, 1'b0);
`else
    if (flip) din = 1'b0;
    if (w == 8'h00) din = 1'b0;
`endif
  endtask

  task automatic send_frame(input logic [7:0] w);
    send_slots(w, 0, 8);
    send_tail(w, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.dout", dout, 8'h00);
    check("reset.sel", sel, 0);
    check("reset.pulses", {dout_valid, err}, 2'b00);

    send_frame(8'hFA);
    check("frame1.dout", dout, 8'hFA);
    check("frame1.valid", dout_valid, 1);
    check("frame1.err", err, 0);

    send_frame(8'h05);
    check("b2b.dout", dout, 8'h05);
    check("b2b.valid", dout_valid, 1);
    idle_cycles(3);

    // Resync at slot 4 aborts 0xC3 and starts 0x3C.
    send_slots(8'hC3, 0, 4);
    send(1'b0, 1'b1);
    check("resync.err", err, 1);
    check("resync.novalid", dout_valid, 0);
    send_slots(8'h3C, 1, 7);
    send_tail(8'h3C, 1'b0);
    check("resync.dout", dout, 8'h3C);
    check("resync.valid", dout_valid, 1);

    // Timeout: 15 idle cycles tolerated, the 16th aborts.
    send_slots(8'h81, 0, 4);
    idle_cycles(15);
    check("timeout.noerr", err, 0);
    check("timeout.sel_hold", sel, 4);
    idle_cycles(1);
    check("timeout.err", err, 1);
    check("timeout.sel", sel, 0);
    check("timeout.dout", dout, 8'h3C);

    // A gap of TIMEOUT-1 mid-frame is still a valid frame.
    send_slots(8'h96, 0, 3);
    idle_cycles(TIMEOUT - 1);
    send_slots(8'h96, 3, 5);
    send_tail(8'h96, 1'b0);
    check("gap.dout", dout, 8'h96);
    check("gap.valid", dout_valid, 1);

    // Sync on the final slot is an early resync.
    send_slots(8'hFF, 0, FRAME - 1);
    send(1'b1, 1'b1);
    check("lastsync.err", err, 1);
    check("lastsync.novalid", dout_valid, 0);
    send_slots(8'h5B, 1, 7);
    send_tail(8'h5B, 1'b0);
    check("lastsync.dout", dout, 8'h5B);

    // Reset after slot 5.
    send_slots(8'hE7, 0, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.dout", dout, 8'h00);
    check("midrst.sel", sel, 0);
    check("midrst.pulses", {dout_valid, err}, 2'b00);
    rst = 1'b0;
    send_frame(8'hA5);
    check("postrst.dout", dout, 8'hA5);

`ifdef TDM_DEMUX8_PARITY_EN
    send_frame(8'hFA);
    check("par.ok.valid", dout_valid, 1);
    check("par.ok.err", err, 0);
    send_slots(8'hFA, 0, 8);
    send_tail(8'hFA, 1'b1);
    check("par.bad.dout", dout, 8'hFA);
    check("par.bad.valid", dout_valid, 1);
    check("par.bad.err", err, 1);
`endif

    idle_cycles(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tdm_demux8.md
# tdm_demux8

Receive-side counterpart of the 8:1 selector. It accepts a time-division serial stream in which one bit per slot is taken from an 8-bit word, slot order 0..7, with a sync strobe on slot 0. It rebuilds the 8-bit parallel word and presents it with a one-cycle valid pulse. It sits at the far end of the serial link, and its slot counter reproduces the sel2/sel1/sel0 sequence used by the sender.

## Interface
Parameters:
- TIMEOUT, default 16: idle cycles allowed mid-frame with no din_valid before the frame is aborted. Legal range 2..255.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial data bit; qualified by din_valid.
- din_valid  in  1  slot strobe; one asserted cycle = one slot.
- sync  in  1  frame marker; meaningful only when din_valid=1, and marks slot 0.
- dout  out  8  reconstructed word; dout[k] = bit received in slot k.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- sel  out  3  slot index expected next; sel[2:0] corresponds to sel2, sel1, sel0.
- err  out  1  one-cycle pulse on a framing error.

## Operation
- Reset: state=HUNT, sel=0, dout=8'h00, dout_valid=0, err=0, shift buffer=0, idle counter=0.
- HUNT state:
  - din_valid without sync is ignored.
  - din_valid&&sync: buf[0]<=din, sel<=1, state<=RECV.
- RECV state, din_valid&&!sync:
  - buf[sel]<=din, and the idle counter clears.
  - If sel!=LAST: sel<=sel+1.
  - If sel==LAST: dout<=assembled word, dout_valid<=1, sel<=0, state<=HUNT.
- LAST is 7 without parity and 8 with parity. The slot counter is 4 bits internally; the sel output shows the low 3 bits.
- RECV state, din_valid&&sync (early resync):
  - err<=1.
  - The partial frame is discarded.
  - buf[0]<=din, sel<=1, state stays RECV.
- RECV state, no din_valid:
  - The idle counter increments.
  - When the counter reaches TIMEOUT: err<=1, sel<=0, state<=HUNT, partial frame discarded, dout unchanged.
- dout holds its last completed word indefinitely.
- Frames that are aborted never reach dout.
- sel wrap-around never occurs: the counter is forced to 0 on completion and on abort.
- Reset asserted mid-frame overrides everything and returns to the reset values on the next edge.

## Timing
- Latency: dout/dout_valid are registered. They assert on the edge after the final-slot bit is sampled, i.e. 1 cycle after that din_valid cycle.
- dout_valid is exactly 1 cycle wide. err is exactly 1 cycle wide.
- Back-to-back frames: a sync in the cycle immediately after the final slot is accepted, because the block is already in HUNT. Zero gap is supported.
- Slots may be spaced arbitrarily, with din_valid gaps, as long as each gap is shorter than TIMEOUT cycles.
- A sync on the final slot is an early resync, not a completion: err=1, no dout_valid.
- err and dout_valid never assert in the same cycle, except for a parity error (see Configuration).

## Configuration
- Macro: TDM_DEMUX8_PARITY_EN.
- Defined:
  - The frame is 9 slots; slot 8 carries even parity over slots 0..7.
  - On completion, dout and dout_valid update as usual.
  - err pulses in the same cycle as dout_valid if the XOR of the 8 data bits and the parity bit is 1.
- Undefined: the frame is 8 slots and no parity logic is instantiated.

## Test plan
- Reset, then a frame with sync on slot 0 and din sequence 0,1,0,1,1,1,1,1 on consecutive cycles -> dout=8'hFA and dout_valid=1 for one cycle, 1 cycle after slot 7; err=0.
- Two back-to-back frames 8'hFA then 8'h05 with no gap -> two dout_valid pulses 8 cycles apart, with dout=8'hFA then 8'h05.
- Sync reasserted at slot 4 -> err pulse; the new frame completes normally 8 slots later; no dout_valid for the aborted frame.
- Slots 0..3 sent, then din_valid held low for TIMEOUT=16 cycles -> err pulse, sel=0, dout keeps its previous value; a later full frame decodes correctly.
- Reset asserted after slot 5 -> next edge gives dout=0, sel=0, no pulses; the next full frame decodes correctly.
- With TDM_DEMUX8_PARITY_EN, frame 8'hFA with parity bit 0 -> dout_valid, err=0; same frame with parity bit 1 -> dout=8'hFA with err=1 in the same cycle.
